// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Four-requester round-robin arbiter driving a shared data mux. A grant lasts
//   while the owner keeps requesting. Once the owner has held the grant for
//   MAX_GRANT_CYCLES cycles, it is pre-empted if any other requester is
//   waiting. A released grant passes to the next round-robin winner at the
//   same edge, so there is no idle gap. Enable low revokes the grant but keeps
//   the round-robin pointer.
//
// Ports
//   Clk_In              in  1           rising-edge clock
//   Reset_In            in  1           asynchronous active-high reset
//   Enable_In           in  1           arbitration enable
//   Req_In              in  4           per-requester request
//   Data_0..3_In        in  DATA_WIDTH  requester data paths
//   Grant_Out           out 4           registered one-hot grant (or zero)
//   Select_Out          out 2           registered index of current/last owner
//   Valid_Out           out 1           registered, high when a grant is active
//   MUX_Result_Data_Out out DATA_WIDTH  selected data, zero when no live grant
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int DATA_WIDTH       = 8,
  parameter int MAX_GRANT_CYCLES = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [3:0]            Req_In,
  input  logic [DATA_WIDTH-1:0] Data_0_In,
  input  logic [DATA_WIDTH-1:0] Data_1_In,
  input  logic [DATA_WIDTH-1:0] Data_2_In,
  input  logic [DATA_WIDTH-1:0] Data_3_In,
  output logic [3:0]            Grant_Out,
  output logic [1:0]            Select_Out,
  output logic                  Valid_Out,
  output logic [DATA_WIDTH-1:0] MUX_Result_Data_Out
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_HOLD = 8'(MAX_GRANT_CYCLES);

  // Round-robin search starting after 'last'. Returns {found, index}.
  // Candidates are scanned from farthest to nearest so that the nearest one
  // (last+1) overwrites the others. The pointer itself comes last in the order.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] pick_v;
    logic [1:0] cand_v;
    pick_v = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand_v = last + 2'(k);
      if (req[cand_v]) begin
        pick_v = {1'b1, cand_v};
      end else begin
        pick_v = pick_v;
      end
    end
    return pick_v;
  endfunction

  state_t     state_r, state_s;
  logic [3:0] grant_r, grant_s;
  logic [1:0] select_r, select_s;
  logic [1:0] last_r, last_s;
  logic [7:0] hold_r, hold_s;
  logic       valid_r;
  logic [3:0] others_s;
  logic [2:0] pick_all_s;
  logic [2:0] pick_oth_s;
  logic       owner_req_s;
  logic       preempt_s;

  // Next-state, grant, pointer and hold-count computation.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    select_s    = select_r;
    last_s      = last_r;
    hold_s      = hold_r;
    // Others = every request except the current owner's. In IDLE the grant is
    // zero, so this equals Req_In. Searching only 'others' on release means the
    // owner can never win again at its own release edge.
    others_s    = Req_In & ~grant_r;
    pick_all_s  = rr_pick(Req_In, last_r);
    pick_oth_s  = rr_pick(others_s, last_r);
    owner_req_s = |(Req_In & grant_r);
    preempt_s   = (hold_r >= MAX_HOLD) && (|others_s);

    if (!Enable_In) begin
      state_s = ST_IDLE;
      grant_s = 4'b0000;
      hold_s  = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_all_s[2]) begin
            state_s  = ST_GRANT;
            grant_s  = 4'b0001 << pick_all_s[1:0];
            select_s = pick_all_s[1:0];
            last_s   = pick_all_s[1:0];
            hold_s   = 8'd1;
          end else begin
            grant_s = 4'b0000;
            hold_s  = 8'd0;
          end
        end
        ST_GRANT: begin
          if (owner_req_s && !preempt_s) begin
            // Owner keeps the grant; the count saturates at the limit.
            if (hold_r < MAX_HOLD) begin
              hold_s = hold_r + 8'd1;
            end else begin
              hold_s = hold_r;
            end
          end else if (pick_oth_s[2]) begin
            grant_s  = 4'b0001 << pick_oth_s[1:0];
            select_s = pick_oth_s[1:0];
            last_s   = pick_oth_s[1:0];
            hold_s   = 8'd1;
          end else begin
            state_s = ST_IDLE;
            grant_s = 4'b0000;
            hold_s  = 8'd0;
          end
        end
        default: begin
          state_s = ST_IDLE;
          grant_s = 4'b0000;
          hold_s  = 8'd0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_r  <= ST_IDLE;
      grant_r  <= 4'b0000;
      select_r <= 2'd0;
      last_r   <= 2'd3;
      hold_r   <= 8'd0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      select_r <= select_s;
      last_r   <= last_s;
      hold_r   <= hold_s;
      valid_r  <= (state_s == ST_GRANT);
    end
  end

  assign Grant_Out  = grant_r;
  assign Select_Out = select_r;
  assign Valid_Out  = valid_r;

  // Shared data mux. Its output is gated to zero at once when enable drops.
  always_comb begin
    MUX_Result_Data_Out = {DATA_WIDTH{1'b0}};
    if (valid_r && Enable_In) begin
      case (select_r)
        2'd0:    MUX_Result_Data_Out = Data_0_In;
        2'd1:    MUX_Result_Data_Out = Data_1_In;
        2'd2:    MUX_Result_Data_Out = Data_2_In;
        2'd3:    MUX_Result_Data_Out = Data_3_In;
        default: MUX_Result_Data_Out = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      MUX_Result_Data_Out = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed-vector bench for mux_rr_arbiter. A behavioural model tracks the
//   owner, the pointer and the hold length as plain integers. It is checked on
//   every falling edge. Hand-computed literal checks pin each scenario.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int DW  = 8;
  localparam int MAX = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [3:0]    req;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [3:0]    grant;
  logic [1:0]    sel;
  logic          valid;
  logic [DW-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  mux_rr_arbiter #(.DATA_WIDTH(DW), .MAX_GRANT_CYCLES(MAX)) dut (
    .Clk_In              (clk),
    .Reset_In            (rst),
    .Enable_In           (en),
    .Req_In              (req),
    .Data_0_In           (d0),
    .Data_1_In           (d1),
    .Data_2_In           (d2),
    .Data_3_In           (d3),
    .Grant_Out           (grant),
    .Select_Out          (sel),
    .Valid_Out           (valid),
    .MUX_Result_Data_Out (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner;  // -1 when nobody holds the grant
  int m_last;
  int m_sel;
  int m_held;   // cycles the current owner has held the grant, capped at MAX

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_sel   = 0;
      m_held  = 0;
    end else if (!en) begin
      m_owner = -1;
      m_held  = 0;
    end else begin
      bit keep;
      bit others;
      int w;
      keep = 1'b0;
      if (m_owner >= 0) begin
        others = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1'b1;
        keep = req[m_owner] && !(m_held >= MAX && others);
      end
      if (keep) begin
        m_held = (m_held + 1 > MAX) ? MAX : m_held + 1;
      end else begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m_last + k) % 4;
          if (w < 0 && idx != m_owner && req[idx]) w = idx;
        end
        if (w >= 0) begin
          m_owner = w; m_last = w; m_sel = w; m_held = 1;
        end else begin
          m_owner = -1; m_held = 0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] pick_data(input int idx);
    case (idx)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0]    exp_g;
    logic [DW-1:0] exp_r;
    exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    exp_r = (m_owner >= 0 && en) ? pick_data(m_sel) : 8'h00;
    chk("model_grant",  32'(grant),  32'(exp_g));
    chk("model_valid",  32'(valid),  32'(m_owner >= 0));
    chk("model_select", 32'(sel),    32'(m_sel));
    chk("model_result", 32'(result), 32'(exp_r));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  logic [4:0] stim [24];

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    d0 = 8'h3C; d1 = 8'hA5; d2 = 8'h5A; d3 = 8'hC3;
    tick(); tick();
    chk("rst_grant",  32'(grant),  32'h0);
    chk("rst_valid",  32'(valid),  32'h0);
    chk("rst_select", 32'(sel),    32'h0);
    chk("rst_result", 32'(result), 32'h0);

    // Rotation under full load: 0,1,2,3,0 with four cycles each, no gaps.
    rst = 1'b0; en = 1'b1; req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("rot_grant", 32'(grant), 32'(4'b0001 << (((k - 1) / 4) % 4)));
    end

    // Voluntary release with handover to requester 0.
    pulse_reset();
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("vol_grant2", 32'(grant), 32'h4);
    end
    req = 4'b0001;
    tick();
    chk("vol_grant0", 32'(grant), 32'h1);

    // Sole requester keeps the grant indefinitely.
    pulse_reset();
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("sole_grant",  32'(grant), 32'h8);
      chk("sole_select", 32'(sel),   32'h3);
    end

    // Data path, then enable drop: output gated at once, grant at next edge.
    pulse_reset();
    req = 4'b0010;
    tick();
    chk("dp_result", 32'(result), 32'hA5);
    en = 1'b0;
    #1;
    chk("dp_gate_result", 32'(result), 32'h00);
    chk("dp_gate_grant",  32'(grant),  32'h2);
    tick();
    chk("dp_off_grant", 32'(grant), 32'h0);
    en = 1'b1;

    // Reset between edges while owner 3 holds the grant.
    pulse_reset();
    req = 4'b1000;
    tick(); tick();
    chk("mid_pre_grant", 32'(grant), 32'h8);
    rst = 1'b1;
    #1;
    chk("mid_grant",  32'(grant),  32'h0);
    chk("mid_valid",  32'(valid),  32'h0);
    chk("mid_select", 32'(sel),    32'h0);
    chk("mid_result", 32'(result), 32'h0);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    chk("mid_first", 32'(grant), 32'h1);

    // Enable recovery: pointer keeps 1, so requester 0 wins next.
    pulse_reset();
    req = 4'b0010;
    tick();
    chk("rec_own1", 32'(grant), 32'h2);
    en = 1'b0;
    tick();
    chk("rec_off_grant",  32'(grant), 32'h0);
    chk("rec_off_select", 32'(sel),   32'h1);
    en = 1'b1; req = 4'b0011;
    tick();
    chk("rec_grant0", 32'(grant), 32'h1);

    // Mixed table of {enable, req}, checked by the model alone.
    stim = '{5'b1_0110, 5'b1_0110, 5'b1_0110, 5'b1_0110, 5'b1_0110, 5'b1_0100,
             5'b1_1100, 5'b1_1000, 5'b0_1000, 5'b1_1011, 5'b1_1011, 5'b1_0011,
             5'b1_0000, 5'b1_0000, 5'b1_1111, 5'b1_1110, 5'b1_1100, 5'b1_1100,
             5'b1_1100, 5'b1_1100, 5'b1_1100, 5'b0_1111, 5'b1_0101, 5'b1_0001};
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h44; d3 = 8'h88;
    for (int i = 0; i < 24; i++) begin
      en  = stim[i][4];
      req = stim[i][3:0];
      tick();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: MUX_RR_ARBITER

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each data input and of the result output.
REQ-002 Parameter MAX_GRANT_CYCLES, default 4, legal range 1..255: the maximum number of consecutive cycles one owner holds the grant while another requester waits.
REQ-003 Clk_In  input  1: the single clock; all state updates occur on its rising edge.
REQ-004 Reset_In  input  1: asynchronous, active-high reset.
REQ-005 Enable_In  input  1: arbitration enable; low blocks new grants and revokes the current grant.
REQ-006 Req_In  input  4: per-requester request; bit i high means requester i wants the shared mux.
REQ-007 Data_0_In, Data_1_In, Data_2_In, Data_3_In  input  DATA_WIDTH each: the requester data paths.
REQ-008 Grant_Out  output  4: one-hot registered grant, or all zeros.
REQ-009 Select_Out  output  2: registered binary index of the current or last owner; it drives the downstream mux select.
REQ-010 Valid_Out  output  1: registered; high exactly when Grant_Out is non-zero.
REQ-011 MUX_Result_Data_Out  output  DATA_WIDTH: combinational. It equals Data_<Select_Out>_In when Valid_Out=1 and Enable_In=1, and is all zeros otherwise.

Function
REQ-012 The FSM SHALL have two states: IDLE (Grant_Out=0) and GRANT (exactly one Grant_Out bit set).
REQ-013 The block SHALL hold a 2-bit Last_Ptr equal to the index of the most recent owner.
REQ-014 Round-robin search: the winner SHALL be the first requesting index found in the order Last_Ptr+1, Last_Ptr+2, Last_Ptr+3, Last_Ptr, mod 4.
REQ-015 IDLE: if Enable_In=1 and Req_In is non-zero at an edge, the FSM SHALL enter GRANT at that edge for the winner, giving 1-cycle request-to-grant latency.
REQ-016 On entering GRANT, the FSM SHALL load Last_Ptr and Select_Out with the winner index and set Hold_Count=1.
REQ-017 GRANT: Hold_Count SHALL increment each cycle the owner keeps the grant, saturating at MAX_GRANT_CYCLES.
REQ-018 Release: the FSM SHALL release the grant at the edge where Req_In[owner]=0, or where Hold_Count=MAX_GRANT_CYCLES and another bit of Req_In is set.
REQ-019 On release, if any other request is pending, the FSM SHALL grant the round-robin winner at the same edge with no idle gap; otherwise it SHALL enter IDLE.
REQ-020 The owner SHALL never win the round-robin search at its own pre-emption edge.
REQ-021 If the owner is the only requester, it SHALL keep the grant indefinitely, with Hold_Count saturated.
REQ-022 Enable_In=0 at an edge SHALL force IDLE with Grant_Out=0 and Valid_Out=0.
REQ-023 Enable_In=0 SHALL leave Last_Ptr and Select_Out unchanged.
REQ-024 Simultaneous events: if the owner drops its request in the same cycle other requests rise, the handover SHALL follow REQ-019.
REQ-025 Grant_Out and Valid_Out SHALL be mutually consistent every cycle (Valid_Out equals the OR of the Grant_Out bits).
REQ-026 Select_Out SHALL equal the index of the set Grant_Out bit whenever Valid_Out=1.

Reset
REQ-027 While Reset_In=1: state=IDLE, Grant_Out=4'b0000, Valid_Out=0, Select_Out=2'd0, Hold_Count=0, Last_Ptr=2'd3 (so requester 0 has first priority). MUX_Result_Data_Out consequently reads zero.
REQ-028 Reset asserted mid-grant SHALL clear all outputs immediately (asynchronously), without waiting for a clock edge.
REQ-029 The first grant after reset SHALL follow the REQ-015 latency.

Verification
REQ-030 Reset priority: after reset, Req_In=4'b1111 -> grants rotate 0,1,2,3,0. Each owner holds the grant for 4 cycles; there are no gaps, and Grant_Out is never zero.
REQ-031 Voluntary release: requester 2 requests alone for 3 cycles, then drops its request while Req_In=4'b0001 -> Grant_Out=4'b0100 for 3 cycles, then 4'b0001 at the next edge.
REQ-032 Sole requester: Req_In=4'b1000 held for 20 cycles -> Grant_Out=4'b1000 and Select_Out=3 throughout; no pre-emption occurs.
REQ-033 Data path: owner 1 with Data_1_In=8'hA5 and Data_0_In=8'h3C -> MUX_Result_Data_Out=8'hA5. Then Enable_In=0 -> MUX_Result_Data_Out=8'h00 immediately, and Grant_Out=0 at the next edge.
REQ-034 Reset mid-grant: owner 3 at Hold_Count=2, Reset_In pulsed between clock edges -> all outputs zero immediately. After release, Req_In=4'b1001 -> requester 0 wins first.
REQ-035 Enable recovery: Enable_In goes low while owner 1 holds the grant, then returns high with Req_In=4'b0011 -> requester 0 wins, because Last_Ptr=1 so the search order is 2,3,0,1.
